// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of the two-port ALU arbiter.
// The slave modport is the arbiter's view of the bus; the master modport is the environment's view.
interface alu_arbiter_if;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic [OP_W-1:0]   alu_operation;
    logic [DATA_W-1:0] alu_operand_a;
    logic [DATA_W-1:0] alu_operand_b;
    logic [DATA_W-1:0] alu_result;

    logic              resp_valid;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_ready;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, resp_ready,
        output req0_ready, req1_ready,
        output alu_operation, alu_operand_a, alu_operand_b,
        output resp_valid, resp_id, resp_result
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_operation, alu_operand_a, alu_operand_b,
        input  resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (capture result) -> RESP (hold until taken).
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              id_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              resp_valid_q;
    logic              grant_c;
    logic              grant_id_c;

    // Next state and grant decision; a grant can only happen in IDLE.
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        grant_id_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_c = 1'b1;
                    if (bus.req0_valid && bus.req1_valid) begin
                        grant_id_c = RR_EN ? ~last_grant_q : 1'b0;
                    end else begin
                        grant_id_c = ~bus.req0_valid;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is the acceptance strobe itself, so it must follow valid in the same cycle.
    assign bus.req0_ready = grant_c && !grant_id_c && !rst;
    assign bus.req1_ready = grant_c &&  grant_id_c && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_c) begin
                last_grant_q <= grant_id_c;
                id_q         <= grant_id_c;
                op_q         <= grant_id_c ? bus.req1_op : bus.req0_op;
                a_q          <= grant_id_c ? bus.req1_a  : bus.req0_a;
                b_q          <= grant_id_c ? bus.req1_b  : bus.req0_b;
            end
            if (state_q == EXEC) begin
                result_q     <= bus.alu_result;
                resp_valid_q <= 1'b1;
            end else if (state_q == RESP && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    // The ALU only ever sees latched operands.
    assign bus.alu_operation = op_q;
    assign bus.alu_operand_a = a_q;
    assign bus.alu_operand_b = b_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = id_q;
    assign bus.resp_result   = result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one round-robin and one fixed-priority instance share stimulus;
// the selected instance is checked against a transaction-level model of grant, timing and result.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    logic sel;
    logic model_last;
    int   errors;
    int   checks;

    alu_arbiter_if r_if ();
    alu_arbiter_if f_if ();

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(r_if));
    alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(f_if));

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a & b;
            4'h2:    return a | b;
            4'h3:    return a ^ b;
            4'h6:    return a - b;
            default: return 32'h0;
        endcase
    endfunction

    assign r_if.alu_result = alu_ref(r_if.alu_operation, r_if.alu_operand_a, r_if.alu_operand_b);
    assign f_if.alu_result = alu_ref(f_if.alu_operation, f_if.alu_operand_a, f_if.alu_operand_b);

    wire        rdy0  = sel ? f_if.req0_ready    : r_if.req0_ready;
    wire        rdy1  = sel ? f_if.req1_ready    : r_if.req1_ready;
    wire        rvld  = sel ? f_if.resp_valid    : r_if.resp_valid;
    wire        rid   = sel ? f_if.resp_id       : r_if.resp_id;
    wire [31:0] rres  = sel ? f_if.resp_result   : r_if.resp_result;
    wire [3:0]  aop   = sel ? f_if.alu_operation : r_if.alu_operation;
    wire [31:0] aopa  = sel ? f_if.alu_operand_a : r_if.alu_operand_a;
    wire [31:0] aopb  = sel ? f_if.alu_operand_b : r_if.alu_operand_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [3:0] o0, input logic [3:0] o1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1);
        r_if.req0_valid = v0; r_if.req0_op = o0; r_if.req0_a = a0; r_if.req0_b = b0;
        r_if.req1_valid = v1; r_if.req1_op = o1; r_if.req1_a = a1; r_if.req1_b = b1;
        f_if.req0_valid = v0; f_if.req0_op = o0; f_if.req0_a = a0; f_if.req0_b = b0;
        f_if.req1_valid = v1; f_if.req1_op = o1; f_if.req1_a = a1; f_if.req1_b = b1;
    endtask

    task automatic set_resp_ready(input logic v);
        r_if.resp_ready = v;
        f_if.resp_ready = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(rvld), 32'h0);
        chk({tag, "_resp_id"}, 32'(rid), 32'h0);
        chk({tag, "_resp_result"}, rres, 32'h0);
        chk({tag, "_alu_operation"}, 32'(aop), 32'h0);
        chk({tag, "_alu_operand_a"}, aopa, 32'h0);
        chk({tag, "_alu_operand_b"}, aopb, 32'h0);
    endtask

    // Reset with both requesters asserting valid: no ready may be seen while rst is high.
    task automatic do_reset();
        drive(1'b1, 1'b1, 4'h0, 4'h1, 32'h1, 32'h2, 32'h3, 32'h4);
        set_resp_ready(1'b1);
        rst = 1'b1;
        #1;
        chk("rst_ready0", 32'(rdy0), 32'h0);
        chk("rst_ready1", 32'(rdy1), 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check_reset_outputs("rst");
        model_last = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_ready0", 32'(rdy0), 32'h0);
            chk("idle_ready1", 32'(rdy1), 32'h0);
            chk("idle_resp_valid", 32'(rvld), 32'h0);
            tick();
        end
    endtask

    // One accepted operation: grant at T, EXEC at T+1, response from T+2 held for `stall` cycles.
    task automatic run_txn(input logic v0, input logic v1, input logic [3:0] o0, input logic [3:0] o1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1,
                           input int stall, input bit abort);
        logic        g;
        logic [3:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] eres;
        drive(v0, v1, o0, o1, a0, b0, a1, b1);
        set_resp_ready(1'b1);
        #1;
        if (v0 && v1) g = sel ? 1'b0 : ~model_last;
        else          g = ~v0;
        chk("grant_ready0", 32'(rdy0), 32'(g == 1'b0));
        chk("grant_ready1", 32'(rdy1), 32'(g == 1'b1));
        model_last = g;
        eop  = g ? o1 : o0;
        ea   = g ? a1 : a0;
        eb   = g ? b1 : b0;
        eres = alu_ref(eop, ea, eb);
        tick();
        chk("exec_ready0", 32'(rdy0), 32'h0);
        chk("exec_ready1", 32'(rdy1), 32'h0);
        chk("exec_resp_valid", 32'(rvld), 32'h0);
        chk("exec_alu_operation", 32'(aop), 32'(eop));
        chk("exec_alu_operand_a", aopa, ea);
        chk("exec_alu_operand_b", aopb, eb);
        tick();
        chk("resp_valid", 32'(rvld), 32'h1);
        chk("resp_id", 32'(rid), 32'(g));
        chk("resp_result", rres, eres);
        chk("resp_ready0", 32'(rdy0), 32'h0);
        chk("resp_ready1", 32'(rdy1), 32'h0);
        if (abort) begin
            rst = 1'b1;
            #1;
            chk("abort_ready0", 32'(rdy0), 32'h0);
            chk("abort_ready1", 32'(rdy1), 32'h0);
            tick();
            rst = 1'b0;
            check_reset_outputs("abort");
            model_last = 1'b1;
            return;
        end
        if (stall > 0) set_resp_ready(1'b0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_resp_valid", 32'(rvld), 32'h1);
            chk("stall_resp_id", 32'(rid), 32'(g));
            chk("stall_resp_result", rres, eres);
            chk("stall_ready0", 32'(rdy0), 32'h0);
            chk("stall_ready1", 32'(rdy1), 32'h0);
        end
        set_resp_ready(1'b1);
        tick();
        chk("done_resp_valid", 32'(rvld), 32'h0);
    endtask

    task automatic random_txns(input int n);
        logic [3:0] ops [8];
        int         v;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'hF, 4'h9, 4'h4};
        for (int k = 0; k < n; k++) begin
            v = $urandom_range(1, 3);
            run_txn(v[0], v[1], ops[$urandom_range(0, 7)], ops[$urandom_range(0, 7)],
                    $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 1'b0;
        rst    = 1'b1;
        model_last = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        set_resp_ready(1'b1);

        // Round-robin instance
        do_reset();
        idle_cycles(2);
        run_txn(1'b1, 1'b0, 4'h0, 4'h0, 32'd5, 32'd7, 32'h0, 32'h0, 0, 1'b0);
        chk("r027_result_sum", 32'(alu_ref(4'h0, 32'd5, 32'd7)), 32'd12);
        do_reset();
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 4'h6, 4'h1, 32'd10, 32'd3, 32'hF0, 32'h3C, 0, 1'b0);
        run_txn(1'b1, 1'b0, 4'h3, 4'h0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 32'h0, 5, 1'b0);
        run_txn(1'b0, 1'b1, 4'h0, 4'hF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
        run_txn(1'b1, 1'b1, 4'h2, 4'h0, 32'hA, 32'h5, 32'h9, 32'h9, 2, 1'b1);
        idle_cycles(2);
        run_txn(1'b1, 1'b1, 4'h0, 4'h6, 32'd1, 32'd2, 32'd9, 32'd4, 0, 1'b0);
        random_txns(40);

        // Fixed-priority instance
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 4'h6, 4'h1, 32'd10, 32'd3, 32'hF0, 32'h3C, 0, 1'b0);
        run_txn(1'b0, 1'b1, 4'h1, 4'h1, 32'h0, 32'h0, 32'hF0, 32'h3C, 1, 1'b0);
        random_txns(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
